// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor.
// Holds the 2-bit counter state encoding and the default geometry.
package bp_pkg;

    localparam int HIST_W_DEF = 4;
    localparam int PC_LSB_DEF = 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating counter.
// Ports: cur (present state), inc (1 = count up), nxt (next state).
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic inc,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        unique case (cur)
            CTR_SNT: nxt = inc ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = inc ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = inc ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = inc ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor with a 2**HIST_W entry PHT of 2-bit counters.
// Ports: clk, reset (sync, active high); predict: pred_req, pred_pc ->
// pred_valid, pred_taken, pred_hist (1-cycle latency); update: upd_valid,
// upd_pc, upd_hist, upd_taken, upd_mispredict (mispredict restores history).
// Macro GSHARE_HASH_EN: index = pc bits XOR history; undefined: history only.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int HIST_W = HIST_W_DEF,
    parameter int PC_LSB = PC_LSB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_req,
    input  logic [31:0]       pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              upd_mispredict
);

    localparam int DEPTH = 1 << HIST_W;

    ctr_t              pht [DEPTH];
    logic [HIST_W-1:0] spec_ghr;
    logic [HIST_W-1:0] pred_idx;
    logic [HIST_W-1:0] upd_idx;
    logic              pred_dir;
    ctr_t              upd_cur;
    ctr_t              upd_nxt;

    // PC bits outside the hash window (all of them in the GAg build)
    // are intentionally ignored.
    logic unused_pc;
    assign unused_pc = ^{pred_pc, upd_pc};

    always_comb begin
        pred_idx = spec_ghr;
        upd_idx  = upd_hist;
`ifdef GSHARE_HASH_EN
        pred_idx = pred_pc[PC_LSB +: HIST_W] ^ spec_ghr;
        upd_idx  = upd_pc[PC_LSB +: HIST_W] ^ upd_hist;
`else
        pred_idx = spec_ghr;
        upd_idx  = upd_hist;
`endif
    end

    // Reads see the pre-edge PHT, so a same-index update is not bypassed.
    assign pred_dir = pht[pred_idx][1];
    assign upd_cur  = pht[upd_idx];

    sat_counter2 u_ctr (
        .cur (upd_cur),
        .inc (upd_taken),
        .nxt (upd_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_WNT;
            end
            spec_ghr   <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_taken <= pred_dir;
                pred_hist  <= spec_ghr;
            end
            if (upd_valid) begin
                pht[upd_idx] <= upd_nxt;
            end
            // Recovery wins over the speculative shift.
            if (upd_valid && upd_mispredict) begin
                spec_ghr <= {upd_hist[HIST_W-2:0], upd_taken};
            end else if (pred_req) begin
                spec_ghr <= {spec_ghr[HIST_W-2:0], pred_dir};
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_gshare_predictor;

    localparam int HW    = 4;
    localparam int PLSB  = 2;
    localparam int DEPTH = 1 << HW;

    logic          clk = 1'b0;
    logic          reset;
    logic          pred_req;
    logic [31:0]   pred_pc;
    logic          pred_valid;
    logic          pred_taken;
    logic [HW-1:0] pred_hist;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic [HW-1:0] upd_hist;
    logic          upd_taken;
    logic          upd_mispredict;

    int tests = 0;
    int fails = 0;

    int m_ctr [DEPTH];
    int m_ghr;
    bit e_valid;
    bit e_taken;
    int e_hist;

    always #5 clk = ~clk;

    gshare_predictor #(.HIST_W(HW), .PC_LSB(PLSB)) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_req       (pred_req),
        .pred_pc        (pred_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_hist       (upd_hist),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    function automatic int m_idx(input bit [31:0] pc, input int h);
`ifdef GSHARE_HASH_EN
        return ((pc >> PLSB) % DEPTH) ^ h;
`else
        return h + 0 * int'(pc[0]);
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input bit rst, input bit req, input bit [31:0] pc,
                        input bit uv, input bit [31:0] upc, input int uh,
                        input bit ut, input bit um);
        int pi;
        int ui;
        reset          = rst;
        pred_req       = req;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_hist       = uh[HW-1:0];
        upd_taken      = ut;
        upd_mispredict = um;
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_ghr   = 0;
            e_valid = 0;
            e_taken = 0;
            e_hist  = 0;
        end else begin
            pi      = m_idx(pc, m_ghr);
            e_valid = req;
            if (req) begin
                e_taken = (m_ctr[pi] >= 2);
                e_hist  = m_ghr;
            end
            if (uv) begin
                ui = m_idx(upc, uh);
                if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
            if (uv && um)
                m_ghr = ((uh << 1) | int'(ut)) % DEPTH;
            else if (req)
                m_ghr = ((m_ghr << 1) | int'(e_taken)) % DEPTH;
        end
        @(posedge clk);
        #1;
        chk("pred_valid", int'(pred_valid), int'(e_valid));
        if (e_valid || rst) begin
            chk("pred_taken", int'(pred_taken), int'(e_taken));
            chk("pred_hist", int'(pred_hist), e_hist);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 1, 1);

        // Prediction from fresh reset, history stays zero.
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r30_taken", int'(pred_taken), 0);
        chk("r30_hist", int'(pred_hist), 0);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r30_hist2", int'(pred_hist), 0);

        // Saturating training toward taken.
        repeat (3) step(0, 0, 0, 1, 32'h10, 0, 1, 0);
        step(0, 1, 32'h10, 0, 0, 0, 0, 0);
        chk("r31_taken", int'(pred_taken), 1);
        chk("r31_hist", int'(pred_hist), 0);

        // Recovery with a concurrent prediction; history is now 0001.
        step(0, 1, 32'h0, 1, 32'h0, 4'b1010, 1, 1);
        chk("r32_old_hist", int'(pred_hist), 1);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r32_new_hist", int'(pred_hist), 5);

        // Same-index predict and update: no bypass.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0, 1, 32'h0, 0, 1, 0);
        chk("r33_nobypass", int'(pred_taken), 0);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r33_after", int'(pred_taken), 1);
        idle();

        // History shift sequence from 0001.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0, 0, 1, 1);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r34_h0", int'(pred_hist), 1);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r34_h1", int'(pred_hist), 2);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r34_h2", int'(pred_hist), 4);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        chk("r34_h3", int'(pred_hist), 8);
        idle();

        // PC aliasing in the history-only build.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 32'h4, 0, 1, 0);
        step(0, 1, 32'h8, 0, 0, 0, 0, 0);
`ifdef GSHARE_HASH_EN
        chk("r35_hash", int'(pred_taken), 0);
`else
        chk("r35_alias", int'(pred_taken), 1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 40) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom,
                 $urandom_range(0, 1) == 1,
                 $urandom,
                 int'($urandom % DEPTH),
                 $urandom_range(0, 1) == 1,
                 ($urandom % 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter HIST_W, default 4: global history bits and PHT index width; PHT depth 2**HIST_W; legal range 2..12.
REQ-002 SHALL have parameter PC_LSB, default 2: lowest PC bit used in the index hash.
REQ-003 clk  in  1  sole clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pred_req  in  1  fetch requests a prediction this cycle.
REQ-006 pred_pc  in  32  PC of the branch being predicted.
REQ-007 pred_valid  out  1  registered; high one cycle after an accepted pred_req.
REQ-008 pred_taken  out  1  registered prediction, valid while pred_valid is high.
REQ-009 pred_hist  out  HIST_W  speculative history used for that prediction; fetch carries it to resolve.
REQ-010 upd_valid  in  1  a branch resolved this cycle.
REQ-011 upd_pc  in  32  PC of the resolved branch.
REQ-012 upd_hist  in  HIST_W  the pred_hist returned when that branch was predicted.
REQ-013 upd_taken  in  1  actual outcome.
REQ-014 upd_mispredict  in  1  the earlier prediction was wrong.

Function
REQ-015 Index SHALL be pc[PC_LSB +: HIST_W] XOR history (see REQ-026).
REQ-016 Each PHT entry SHALL be a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken when bit[1] is 1.
REQ-017 Accepted pred_req SHALL read PHT[idx(pred_pc, spec_ghr)] and register pred_taken and pred_hist=spec_ghr; latency is exactly 1 cycle.
REQ-018 On the same edge, spec_ghr SHALL shift left and insert the predicted direction in bit 0.
REQ-019 upd_valid SHALL modify PHT[idx(upd_pc, upd_hist)] only: +1 if taken, -1 if not taken, saturating at 11 and 00.
REQ-020 upd_valid with upd_mispredict SHALL load spec_ghr <= {upd_hist[HIST_W-2:0], upd_taken}.
REQ-021 Recovery SHALL take priority over the REQ-018 shift in the same cycle; the concurrent prediction is still produced using the pre-recovery history.
REQ-022 Predict and update to the same index in one cycle SHALL predict from the old counter value; there is no bypass.
REQ-023 upd_valid without upd_mispredict SHALL leave spec_ghr unchanged apart from any concurrent REQ-018 shift.
REQ-024 pred_valid SHALL fall the cycle after pred_req is low; back-to-back requests SHALL be accepted every cycle.

Reset
REQ-025 While reset is high: every PHT entry = 01, spec_ghr = 0, pred_valid = 0, pred_taken = 0, pred_hist = 0; all requests and updates are ignored; reset mid-stream discards in-flight predictions.

Configuration
REQ-026 Macro GSHARE_HASH_EN defined: index per REQ-015; undefined: index = history only, PC ignored (pure GAg).
REQ-027 In both builds the ports and the counter, history and recovery behaviour are identical.

Structure
REQ-028 Package bp_pkg SHALL hold the 2-bit counter state enum and the default HIST_W/PC_LSB constants.
REQ-029 One sub-module, sat_counter2 (combinational next-state of a 2-bit saturating counter), SHALL be instantiated for the update path.

Verification
REQ-030 Reset, then pred_req with pc=0x0 -> next cycle pred_valid=1, pred_taken=0, pred_hist=0000; spec_ghr stays 0000.
REQ-031 Three updates taken at pc=0x10, hist=0000, no mispredict -> that entry goes 01->10->11->11; a later prediction at that index gives taken.
REQ-032 upd_mispredict with upd_hist=1010 and upd_taken=1, plus pred_req in the same cycle -> spec_ghr=0101; that prediction's pred_hist is the old value.
REQ-033 Update and predict to the same index, counter 01, taken -> pred_taken=0 this time; the next prediction gives 1.
REQ-034 Four consecutive pred_req, all predicted NT, starting from spec_ghr=0001 -> pred_hist sequence 0001, 0010, 0100, 1000.
REQ-035 With GSHARE_HASH_EN undefined, pcs 0x4 and 0x8 under equal history -> both hit the same entry.
